mc_cu: RTL and testbench
========================

Name: mc_cu

Overview:
- Multi-cycle control unit for the MIPS-subset CPU; it is the next generation of the single-cycle decoder.
- Decodes op/func from the instruction register and steps a state machine: IF, ID, EXE, MEM, WB, plus an MD wait state for multi-cycle mult/div.
- Produces per-state datapath enables, so the datapath can share one memory and one ALU.
- Adds parametrised mult/div latency, an optional mult/div opcode set, busy and illegal-instruction flags.

Parameters:
- MD_CYCLES, 4: number of cycles spent in MD for mult/div; legal range 1..255.
- ENABLE_MULDIV, 1: when 0, mult and div decode as illegal.

Ports:
- clock  in  1  single system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- op  in  6  opcode from IR; stable from ID to end of instruction.
- func  in  6  function field from IR.
- z  in  1  ALU zero flag, valid combinationally in EXE.
- pcwrite  out  1  PC load enable.
- irwrite  out  1  IR load enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register.
- wmem  out  1  memory write enable.
- wreg  out  1  register-file write enable.
- regrt, m2reg, shift, aluimm, sext, jal  out  1 each  datapath selects; same meaning as the single-cycle unit.
- aluc  out  4  ALU operation.
- pcsource  out  2  next-PC select: 00 = PC+4, 01 = branch target, 10 = rs (jr), 11 = jump target.
- state  out  3  current state: IF=0, ID=1, EXE=2, MEM=3, WB=4, MD=5.
- busy  out  1  high in MD.
- illegal  out  1  one-cycle pulse in ID for an undecoded instruction.

Behaviour:
- Decode encodings:
  - R-type (op 000000) func codes: add 100000, sub 100010, and 100100, or 100101, xor 100110, sll 000000, srl 000010, sra 000011, jr 001000, mult 011000, div 011010, slt 101010, even 111111.
  - Opcodes: addi 001000, andi 001100, ori 001101, xori 001110, lui 001111, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011.
- aluc encodings:
  - add/addi/lw/sw 0000; sub/beq/bne 0100; and/andi 0001; or/ori 0101; xor/xori 0010; lui 0110.
  - sll 0011; srl 0111; sra 1111; mult 1011; div 1010; slt 1110; even 1101.
  - aluc, shift, aluimm and sext are driven from decode in every state.
- Reset:
  - State goes to IF and the MD counter clears to 0.
  - While reset is high, pcwrite, irwrite, wmem and wreg are forced to 0 and illegal to 0.
- IF: irwrite=1, pcwrite=1, iord=0, pcsource=00. Next state is ID.
- ID:
  - j: pcwrite=1, pcsource=11, then IF.
  - jal: as j, plus wreg=1 and jal=1 (link written this cycle), then IF.
  - jr: pcwrite=1, pcsource=10, then IF.
  - Illegal instruction: illegal=1 for one cycle, no writes, then IF (executes as a nop).
  - All other instructions: next state EXE.
- EXE:
  - beq: pcwrite=z, pcsource=01, then IF.
  - bne: pcwrite=~z, pcsource=01, then IF.
  - lw/sw: next state MEM.
  - mult/div: load counter with MD_CYCLES-1, then MD.
  - All others: next state WB.
- MD:
  - busy=1; counter decrements each cycle.
  - When counter==0, next state is WB, so MD lasts exactly MD_CYCLES cycles.
- MEM:
  - iord=1.
  - sw: wmem=1, then IF.
  - lw: next state WB.
- WB:
  - wreg=1; m2reg=1 only for lw.
  - regrt=1 for addi, andi, ori, xori, lw, lui.
  - Next state is IF.
- Default output values: every write enable and select not listed for a state is 0 in that state.
- Instruction latencies (cycles, IF to next IF):
  - j, jal, jr, illegal: 2.
  - beq, bne: 3.
  - R-ALU, I-ALU, sw: 4.
  - lw: 5.
  - mult, div: 4+MD_CYCLES.
- The state encoding values 6 and 7 are unreachable; if entered, the next state is IF with no writes.
- Reset asserted in any state, including mid-MD, aborts the instruction: no wreg pulse, IF on the next cycle.

Test Plan:
- Reset then add (op 000000, func 100000):
  - state sequence 0,1,2,4,0.
  - wreg=1 only in WB; aluc=0000; regrt=0.
- lw (op 100011):
  - states 0,1,2,3,4.
  - iord=1 in MEM; wreg=1 and m2reg=1 and regrt=1 in WB.
- sw, then beq with z=1, then bne with z=1:
  - sw: wmem=1 for exactly one cycle, in MEM.
  - beq: pcwrite=1 in EXE with pcsource=01.
  - bne: pcwrite=0 in EXE.
- mult with MD_CYCLES=4:
  - busy high for exactly 4 cycles.
  - WB follows with aluc=1011; total 8 cycles.
  - Repeat with MD_CYCLES=1: busy high for 1 cycle.
- jal:
  - ID asserts pcwrite, wreg and jal; pcsource=11.
  - 2-cycle instruction.
  - op 111111 gives an illegal pulse and no writes.
  - ENABLE_MULDIV=0 with mult gives illegal=1.
- Reset asserted on the 2nd MD cycle of div:
  - Next state is IF and busy drops.
  - No wreg pulse occurs.

Source files
------------

// File: rtl/mc_cu.sv
// ---------------------------------------------------------------------------
// mc_cu : multi-cycle control unit for the MIPS-subset CPU.
//
// Decodes op/func from the instruction register and sequences each instruction
// through IF -> ID -> EXE -> (MEM | MD) -> WB. Every write enable and datapath
// select is produced per state, so one memory and one ALU can serve all phases.
//
// Parameters
//   MD_CYCLES      cycles spent in MD for mult/div (1..255)
//   ENABLE_MULDIV  0 makes mult/div decode as illegal
//
// Ports
//   clock          system clock, rising edge
//   reset          synchronous, active-high
//   op, func       opcode / function field from IR (stable from ID onward)
//   z              ALU zero flag, valid combinationally in EXE
//   pcwrite        PC load enable
//   irwrite        IR load enable
//   iord           memory address select (0 = PC, 1 = ALU result register)
//   wmem           memory write enable
//   wreg           register-file write enable
//   regrt, m2reg, shift, aluimm, sext, jal   datapath selects
//   aluc           ALU operation
//   pcsource       next-PC select (00 PC+4, 01 branch, 10 rs, 11 jump)
//   state          current state (IF=0 ID=1 EXE=2 MEM=3 WB=4 MD=5)
//   busy           high while in MD
//   illegal        one-cycle pulse in ID for an undecoded instruction
// ---------------------------------------------------------------------------
module mc_cu #(
   parameter int MD_CYCLES     = 4,
   parameter int ENABLE_MULDIV = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic       z,
   output logic       pcwrite,
   output logic       irwrite,
   output logic       iord,
   output logic       wmem,
   output logic       wreg,
   output logic       regrt,
   output logic       m2reg,
   output logic       shift,
   output logic       aluimm,
   output logic       sext,
   output logic       jal,
   output logic [3:0] aluc,
   output logic [1:0] pcsource,
   output logic [2:0] state,
   output logic       busy,
   output logic       illegal
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EXE = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4,
      S_MD  = 3'd5
   } state_t;

   // R-type function codes
   localparam logic [5:0] F_ADD  = 6'b100000;
   localparam logic [5:0] F_SUB  = 6'b100010;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_XOR  = 6'b100110;
   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_SRL  = 6'b000010;
   localparam logic [5:0] F_SRA  = 6'b000011;
   localparam logic [5:0] F_JR   = 6'b001000;
   localparam logic [5:0] F_MULT = 6'b011000;
   localparam logic [5:0] F_DIV  = 6'b011010;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_EVEN = 6'b111111;

   // Opcodes
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_XORI = 6'b001110;
   localparam logic [5:0] OP_LUI  = 6'b001111;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;

   localparam logic       L_MD_EN   = (ENABLE_MULDIV != 0);
   // MD is entered with the counter at MD_CYCLES-1 and left when it reads 0,
   // which gives exactly MD_CYCLES cycles in MD.
   localparam logic [7:0] L_MD_LOAD = 8'(MD_CYCLES - 1);

   state_t     r_state;
   logic [7:0] r_cnt;

   // ------------------------------------------------------------------
   // Instruction decode
   // ------------------------------------------------------------------
   logic w_rtype;
   logic w_add, w_sub, w_and, w_or, w_xor, w_sll, w_srl, w_sra;
   logic w_jr, w_mult, w_div, w_slt, w_even;
   logic w_addi, w_andi, w_ori, w_xori, w_lui;
   logic w_lw, w_sw, w_beq, w_bne, w_j, w_jal;
   logic w_alu_r, w_alu_i, w_muldiv, w_legal, w_illegal;
   logic w_shift, w_aluimm, w_sext, w_regrt;
   logic [3:0] w_aluc;

   assign w_rtype  = (op == OP_R);
   assign w_add    = w_rtype & (func == F_ADD);
   assign w_sub    = w_rtype & (func == F_SUB);
   assign w_and    = w_rtype & (func == F_AND);
   assign w_or     = w_rtype & (func == F_OR);
   assign w_xor    = w_rtype & (func == F_XOR);
   assign w_sll    = w_rtype & (func == F_SLL);
   assign w_srl    = w_rtype & (func == F_SRL);
   assign w_sra    = w_rtype & (func == F_SRA);
   assign w_jr     = w_rtype & (func == F_JR);
   assign w_mult   = w_rtype & (func == F_MULT) & L_MD_EN;
   assign w_div    = w_rtype & (func == F_DIV) & L_MD_EN;
   assign w_slt    = w_rtype & (func == F_SLT);
   assign w_even   = w_rtype & (func == F_EVEN);

   assign w_addi   = (op == OP_ADDI);
   assign w_andi   = (op == OP_ANDI);
   assign w_ori    = (op == OP_ORI);
   assign w_xori   = (op == OP_XORI);
   assign w_lui    = (op == OP_LUI);
   assign w_lw     = (op == OP_LW);
   assign w_sw     = (op == OP_SW);
   assign w_beq    = (op == OP_BEQ);
   assign w_bne    = (op == OP_BNE);
   assign w_j      = (op == OP_J);
   assign w_jal    = (op == OP_JAL);

   assign w_alu_r  = w_add | w_sub | w_and | w_or | w_xor | w_sll | w_srl |
                     w_sra | w_slt | w_even;
   assign w_alu_i  = w_addi | w_andi | w_ori | w_xori | w_lui;
   assign w_muldiv = w_mult | w_div;
   assign w_legal  = w_alu_r | w_alu_i | w_muldiv | w_jr | w_lw | w_sw |
                     w_beq | w_bne | w_j | w_jal;
   assign w_illegal = ~w_legal;

   assign w_shift  = w_sll | w_srl | w_sra;
   assign w_aluimm = w_alu_i | w_lw | w_sw;
   assign w_sext   = w_addi | w_lw | w_sw | w_beq | w_bne;
   assign w_regrt  = w_alu_i | w_lw;

   always_comb begin
      w_aluc = 4'b0000;
      if (w_sub | w_beq | w_bne)  w_aluc = 4'b0100;
      else if (w_and | w_andi)    w_aluc = 4'b0001;
      else if (w_or  | w_ori)     w_aluc = 4'b0101;
      else if (w_xor | w_xori)    w_aluc = 4'b0010;
      else if (w_lui)             w_aluc = 4'b0110;
      else if (w_sll)             w_aluc = 4'b0011;
      else if (w_srl)             w_aluc = 4'b0111;
      else if (w_sra)             w_aluc = 4'b1111;
      else if (w_mult)            w_aluc = 4'b1011;
      else if (w_div)             w_aluc = 4'b1010;
      else if (w_slt)             w_aluc = 4'b1110;
      else if (w_even)            w_aluc = 4'b1101;
   end

   // ------------------------------------------------------------------
   // State register and MD counter
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= S_IF;
         r_cnt   <= 8'd0;
      end else begin
         case (r_state)
            S_IF:  r_state <= S_ID;
            S_ID:  begin
               // jumps and illegal instructions complete in ID
               if (w_j | w_jal | w_jr | w_illegal) r_state <= S_IF;
               else                                r_state <= S_EXE;
            end
            S_EXE: begin
               if (w_beq | w_bne) begin
                  r_state <= S_IF;
               end else if (w_lw | w_sw) begin
                  r_state <= S_MEM;
               end else if (w_muldiv) begin
                  r_cnt   <= L_MD_LOAD;
                  r_state <= S_MD;
               end else begin
                  r_state <= S_WB;
               end
            end
            S_MEM: r_state <= w_lw ? S_WB : S_IF;
            S_MD:  begin
               if (r_cnt == 8'd0) r_state <= S_WB;
               else               r_cnt   <= r_cnt - 8'd1;
            end
            S_WB:  r_state <= S_IF;
            default: r_state <= S_IF;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Per-state outputs. Enables follow the registered state directly; the
   // branch PC write must see z in the same EXE cycle, so these cannot be
   // delayed by a further register stage.
   // ------------------------------------------------------------------
   always_comb begin
      pcwrite  = 1'b0;
      irwrite  = 1'b0;
      iord     = 1'b0;
      wmem     = 1'b0;
      wreg     = 1'b0;
      regrt    = 1'b0;
      m2reg    = 1'b0;
      jal      = 1'b0;
      pcsource = 2'b00;
      busy     = 1'b0;
      illegal  = 1'b0;
      aluc     = w_aluc;
      shift    = w_shift;
      aluimm   = w_aluimm;
      sext     = w_sext;
      state    = r_state;

      case (r_state)
         S_IF: begin
            irwrite = 1'b1;
            pcwrite = 1'b1;
         end
         S_ID: begin
            if (w_j) begin
               pcwrite  = 1'b1;
               pcsource = 2'b11;
            end else if (w_jal) begin
               // link register is written in the same cycle as the jump
               pcwrite  = 1'b1;
               pcsource = 2'b11;
               wreg     = 1'b1;
               jal      = 1'b1;
            end else if (w_jr) begin
               pcwrite  = 1'b1;
               pcsource = 2'b10;
            end else if (w_illegal) begin
               illegal  = 1'b1;
            end
         end
         S_EXE: begin
            if (w_beq) begin
               pcwrite  = z;
               pcsource = 2'b01;
            end else if (w_bne) begin
               pcwrite  = ~z;
               pcsource = 2'b01;
            end
         end
         S_MEM: begin
            iord = 1'b1;
            wmem = w_sw;
         end
         S_WB: begin
            wreg  = 1'b1;
            m2reg = w_lw;
            regrt = w_regrt;
         end
         S_MD: busy = 1'b1;
         default: ;
      endcase

      // reset aborts the current instruction without any architectural write
      if (reset) begin
         pcwrite = 1'b0;
         irwrite = 1'b0;
         wmem    = 1'b0;
         wreg    = 1'b0;
         illegal = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_cu.sv
// ---------------------------------------------------------------------------
// tb_mc_cu : scoreboard bench for mc_cu.
// Three instances cover MD_CYCLES=4, MD_CYCLES=1 and ENABLE_MULDIV=0; the
// instance under test is selected by sel, the others are held in reset.
// The stimulus process pushes one expected output vector per cycle of each
// instruction; the monitor pops and compares on every falling edge.
// ---------------------------------------------------------------------------
module tb_mc_cu;

   typedef enum int {K_J, K_JAL, K_JR, K_ILL, K_BEQ, K_BNE, K_LW, K_SW,
                     K_MD, K_ALU} kind_e;

   typedef struct {
      kind_e      k;
      logic [3:0] aluc;
      logic       shift;
      logic       aluimm;
      logic       sext;
      logic       regrt;
   } dec_t;

   logic       clock = 1'b0;
   logic       rst_drv;
   logic [1:0] sel;
   logic [5:0] op, func;
   logic       z;
   logic       mon_en;
   logic [21:0] vec [3];
   logic [21:0] exp_q [$];
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clock = ~clock;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic pcwrite, irwrite, iord, wmem, wreg, regrt, m2reg, shift, aluimm;
      logic sext, jal, busy, illegal;
      logic [3:0] aluc;
      logic [1:0] pcsource;
      logic [2:0] state;
      mc_cu #(
         .MD_CYCLES     ((g == 1) ? 1 : 4),
         .ENABLE_MULDIV ((g == 2) ? 0 : 1)
      ) u_dut (
         .clock    (clock),
         .reset    (rst_drv | (sel != 2'(g))),
         .op       (op),
         .func     (func),
         .z        (z),
         .pcwrite  (pcwrite),
         .irwrite  (irwrite),
         .iord     (iord),
         .wmem     (wmem),
         .wreg     (wreg),
         .regrt    (regrt),
         .m2reg    (m2reg),
         .shift    (shift),
         .aluimm   (aluimm),
         .sext     (sext),
         .jal      (jal),
         .aluc     (aluc),
         .pcsource (pcsource),
         .state    (state),
         .busy     (busy),
         .illegal  (illegal)
      );
      assign vec[g] = {pcwrite, irwrite, iord, wmem, wreg, regrt, m2reg, shift,
                       aluimm, sext, jal, aluc, pcsource, state, busy, illegal};
   end

   function automatic int md_of(input logic [1:0] s);
      return (s == 2'd1) ? 1 : 4;
   endfunction

   function automatic bit en_of(input logic [1:0] s);
      return (s != 2'd2);
   endfunction

   // Instruction classification from the encoding tables.
   function automatic dec_t tb_decode(input logic [5:0] o, input logic [5:0] f,
                                      input bit en);
      dec_t d;
      d.k = K_ILL; d.aluc = 4'b0000; d.shift = 0; d.aluimm = 0; d.sext = 0;
      d.regrt = 0;
      if (o == 6'b000000) begin
         case (f)
            6'b100000: d.k = K_ALU;
            6'b100010: begin d.k = K_ALU; d.aluc = 4'b0100; end
            6'b100100: begin d.k = K_ALU; d.aluc = 4'b0001; end
            6'b100101: begin d.k = K_ALU; d.aluc = 4'b0101; end
            6'b100110: begin d.k = K_ALU; d.aluc = 4'b0010; end
            6'b000000: begin d.k = K_ALU; d.aluc = 4'b0011; d.shift = 1; end
            6'b000010: begin d.k = K_ALU; d.aluc = 4'b0111; d.shift = 1; end
            6'b000011: begin d.k = K_ALU; d.aluc = 4'b1111; d.shift = 1; end
            6'b001000: d.k = K_JR;
            6'b011000: if (en) begin d.k = K_MD; d.aluc = 4'b1011; end
            6'b011010: if (en) begin d.k = K_MD; d.aluc = 4'b1010; end
            6'b101010: begin d.k = K_ALU; d.aluc = 4'b1110; end
            6'b111111: begin d.k = K_ALU; d.aluc = 4'b1101; end
            default: ;
         endcase
      end else begin
         case (o)
            6'b001000: begin d.k = K_ALU; d.aluimm = 1; d.sext = 1; d.regrt = 1; end
            6'b001100: begin d.k = K_ALU; d.aluc = 4'b0001; d.aluimm = 1; d.regrt = 1; end
            6'b001101: begin d.k = K_ALU; d.aluc = 4'b0101; d.aluimm = 1; d.regrt = 1; end
            6'b001110: begin d.k = K_ALU; d.aluc = 4'b0010; d.aluimm = 1; d.regrt = 1; end
            6'b001111: begin d.k = K_ALU; d.aluc = 4'b0110; d.aluimm = 1; d.regrt = 1; end
            6'b100011: begin d.k = K_LW;  d.aluimm = 1; d.sext = 1; d.regrt = 1; end
            6'b101011: begin d.k = K_SW;  d.aluimm = 1; d.sext = 1; end
            6'b000100: begin d.k = K_BEQ; d.aluc = 4'b0100; d.sext = 1; end
            6'b000101: begin d.k = K_BNE; d.aluc = 4'b0100; d.sext = 1; end
            6'b000010: d.k = K_J;
            6'b000011: d.k = K_JAL;
            default: ;
         endcase
      end
      return d;
   endfunction

   // Expected output vector for one cycle of an instruction.
   function automatic logic [21:0] exp_out(input dec_t d, input int st,
                                           input logic zz, input bit rst);
      logic pcw = 0, irw = 0, iord = 0, wm = 0, wr = 0, rt = 0, m2 = 0, jl = 0;
      logic bsy = 0, ill = 0;
      logic [1:0] pcs = 2'b00;
      case (st)
         0: begin irw = 1; pcw = 1; end
         1: case (d.k)
               K_J:   begin pcw = 1; pcs = 2'b11; end
               K_JAL: begin pcw = 1; pcs = 2'b11; wr = 1; jl = 1; end
               K_JR:  begin pcw = 1; pcs = 2'b10; end
               K_ILL: ill = 1;
               default: ;
            endcase
         2: if (d.k == K_BEQ) begin pcw = zz; pcs = 2'b01; end
            else if (d.k == K_BNE) begin pcw = ~zz; pcs = 2'b01; end
         3: begin iord = 1; wm = (d.k == K_SW); end
         4: begin wr = 1; m2 = (d.k == K_LW); rt = d.regrt; end
         5: bsy = 1;
         default: ;
      endcase
      if (rst) begin pcw = 0; irw = 0; wm = 0; wr = 0; ill = 0; end
      return {pcw, irw, iord, wm, wr, rt, m2, d.shift, d.aluimm, d.sext, jl,
              d.aluc, pcs, 3'(st), bsy, ill};
   endfunction

   // Issue one instruction; abort_at>0 truncates it to that many cycles with
   // reset asserted during the last one.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                            input logic zz, input int abort_at);
      dec_t d;
      int seq[$];
      op = o; func = f; z = zz;
      d = tb_decode(o, f, en_of(sel));
      case (d.k)
         K_J, K_JAL, K_JR, K_ILL: seq = '{0, 1};
         K_BEQ, K_BNE:            seq = '{0, 1, 2};
         K_SW:                    seq = '{0, 1, 2, 3};
         K_LW:                    seq = '{0, 1, 2, 3, 4};
         K_MD: begin
            seq = '{0, 1, 2};
            for (int i = 0; i < md_of(sel); i++) seq.push_back(5);
            seq.push_back(4);
         end
         default:                 seq = '{0, 1, 2, 4};
      endcase
      if (abort_at > 0) while (seq.size() > abort_at) void'(seq.pop_back());
      for (int i = 0; i < seq.size(); i++)
         exp_q.push_back(exp_out(d, seq[i], zz, (abort_at > 0) && (i == seq.size() - 1)));
      for (int i = 0; i < seq.size(); i++) begin
         if ((abort_at > 0) && (i == seq.size() - 1)) rst_drv = 1'b1;
         @(posedge clock); #1;
      end
      rst_drv = 1'b0;
   endtask

   task automatic start_phase(input int k);
      mon_en = 1'b0;
      sel = 2'(k); rst_drv = 1'b1; op = 6'b000000; func = 6'b100000; z = 1'b0;
      @(posedge clock); #1;
      exp_q.push_back(exp_out(tb_decode(op, func, en_of(sel)), 0, z, 1'b1));
      mon_en = 1'b1;
      @(posedge clock); #1;
      rst_drv = 1'b0;
   endtask

   function automatic logic [11:0] pick(input int i);
      case (i)
         0:  return {6'b000000, 6'b100000};
         1:  return {6'b000000, 6'b100010};
         2:  return {6'b000000, 6'b100100};
         3:  return {6'b000000, 6'b100101};
         4:  return {6'b000000, 6'b100110};
         5:  return {6'b000000, 6'b000000};
         6:  return {6'b000000, 6'b000010};
         7:  return {6'b000000, 6'b000011};
         8:  return {6'b000000, 6'b001000};
         9:  return {6'b000000, 6'b011000};
         10: return {6'b000000, 6'b011010};
         11: return {6'b000000, 6'b101010};
         12: return {6'b000000, 6'b111111};
         13: return {6'b001000, 6'(i)};
         14: return {6'b001100, 6'(i)};
         15: return {6'b001101, 6'(i)};
         16: return {6'b001110, 6'(i)};
         17: return {6'b001111, 6'(i)};
         18: return {6'b100011, 6'(i)};
         19: return {6'b101011, 6'(i)};
         20: return {6'b000100, 6'(i)};
         21: return {6'b000101, 6'(i)};
         22: return {6'b000010, 6'(i)};
         default: return {6'b000011, 6'(i)};
      endcase
   endfunction

   task automatic run_random(input int n);
      logic [11:0] e;
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 9) < 8) e = pick($urandom_range(0, 23));
         else e = 12'($urandom);
         run_instr(e[11:6], e[5:0], 1'($urandom), 0);
      end
   endtask

   // Monitor: one expected vector per cycle while monitoring is enabled.
   always @(negedge clock) begin
      if (mon_en) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL underflow: got %h, required no output", vec[sel]);
         end else begin
            logic [21:0] e;
            e = exp_q.pop_front();
            if (vec[sel] !== e) begin
               n_bad++;
               $display("FAIL dut%0d t=%0t outputs: got %h (state %0d) required %h (state %0d) op=%b func=%b",
                        sel, $time, vec[sel], vec[sel][4:2], e, e[4:2], op, func);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: bench did not finish, required completion");
      $fatal(1);
   end

   initial begin
      rst_drv = 1'b1; sel = 2'd0; mon_en = 1'b0;
      op = 6'b0; func = 6'b0; z = 1'b0;

      start_phase(0);
      run_instr(6'b000000, 6'b100000, 1'b0, 0);  // add
      run_instr(6'b100011, 6'b000101, 1'b0, 0);  // lw
      run_instr(6'b101011, 6'b000000, 1'b0, 0);  // sw
      run_instr(6'b000100, 6'b000000, 1'b1, 0);  // beq taken
      run_instr(6'b000101, 6'b000000, 1'b1, 0);  // bne not taken
      run_instr(6'b000000, 6'b011000, 1'b0, 0);  // mult, 4 MD cycles
      run_instr(6'b000011, 6'b000000, 1'b0, 0);  // jal
      run_instr(6'b111111, 6'b000000, 1'b0, 0);  // illegal opcode
      run_instr(6'b000000, 6'b011010, 1'b0, 5);  // div aborted in 2nd MD cycle
      run_instr(6'b000000, 6'b100010, 1'b0, 0);  // sub after abort
      run_instr(6'b000000, 6'b001000, 1'b0, 0);  // jr
      run_random(80);

      start_phase(1);
      run_instr(6'b000000, 6'b011000, 1'b0, 0);  // mult, 1 MD cycle
      run_instr(6'b000000, 6'b011010, 1'b1, 0);  // div
      run_random(40);

      start_phase(2);
      run_instr(6'b000000, 6'b011000, 1'b0, 0);  // mult is illegal here
      run_instr(6'b000000, 6'b011010, 1'b0, 0);  // div is illegal here
      run_random(40);

      mon_en = 1'b0;
      @(posedge clock); #1;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL leftover: got %0d queued, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
